// File: rtl/mux_rezultati_alu_if.sv
// Bus bundle for the ALU result multiplexer: channel data, carries and select
// on the input side, registered result plus flags on the output side.
interface mux_rezultati_alu_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
);
  logic [NUM_IN*WIDTH-1:0] Hyrjet;
  logic [NUM_IN-1:0]       CarryHyrjet;
  logic [SEL_W-1:0]        S;
  logic                    Valid_in;
  logic                    Ready_in;
  logic [WIDTH-1:0]        Dalja;
  logic                    Valid_out;
  logic                    Ready_out;
  logic                    Zero;
  logic                    Negative;
  logic                    Carry;
  logic                    Illegal;

  modport master (
    output Hyrjet, CarryHyrjet, S, Valid_in, Ready_out,
    input  Ready_in, Dalja, Valid_out, Zero, Negative, Carry, Illegal
  );

  modport slave (
    input  Hyrjet, CarryHyrjet, S, Valid_in, Ready_out,
    output Ready_in, Dalja, Valid_out, Zero, Negative, Carry, Illegal
  );
endinterface

// File: rtl/mux_rezultati_alu.sv
// ALU result multiplexer: picks channel S, derives Zero/Negative/Carry/Illegal
// at acceptance time and holds result+flags in a 2-entry skid buffer so that
// Ready_in is a pure register output.
module mux_rezultati_alu #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input logic                Clock,
  input logic                Reset,
  mux_rezultati_alu_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  // Builds one stored entry; an out-of-range select yields a zero word
  // flagged Illegal with no carry.
  function automatic entry_t select_entry(
    input logic [NUM_IN*WIDTH-1:0] h,
    input logic [NUM_IN-1:0]       cy,
    input logic [SEL_W-1:0]        s
  );
    entry_t e;
    e         = '0;
    e.illegal = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(s) == k) begin
        e.data    = h[k*WIDTH +: WIDTH];
        e.carry   = cy[k];
        e.illegal = 1'b0;
      end
    end
    e.zero = (e.data == '0);
    e.neg  = e.data[WIDTH-1];
    return e;
  endfunction

  state_t state_q, state_d;
  entry_t new_p0;
  entry_t out_p1, skid_p1;
  logic   vld_p1;
  logic   ready_q;
  logic   in_xfer, out_xfer;
  logic   load_out_new, load_out_skid, load_skid;

  assign new_p0   = select_entry(bus.Hyrjet, bus.CarryHyrjet, bus.S);
  assign in_xfer  = bus.Valid_in & ready_q;
  assign out_xfer = vld_p1 & bus.Ready_out;

  // Next-state and buffer steering from the two handshakes
  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d      = ONE;
          load_out_new = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_out_new = 1'b1;
        end else if (in_xfer) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d       = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Stage p0 -> p1: state, handshake flags and the output entry
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= EMPTY;
      vld_p1  <= 1'b0;
      ready_q <= 1'b1;
      out_p1  <= '0;
    end else begin
      state_q <= state_d;
      vld_p1  <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
      if (load_out_new) begin
        out_p1 <= new_p0;
      end else if (load_out_skid) begin
        out_p1 <= skid_p1;
      end
    end
  end

  // Skid entry is only meaningful in FULL, so it needs no reset value
  always_ff @(posedge Clock) begin
    if (load_skid) begin
      skid_p1 <= new_p0;
    end
  end

  assign bus.Ready_in  = ready_q;
  assign bus.Valid_out = vld_p1;
  assign bus.Dalja     = out_p1.data;
  assign bus.Zero      = out_p1.zero;
  assign bus.Negative  = out_p1.neg;
  assign bus.Carry     = out_p1.carry;
  assign bus.Illegal   = out_p1.illegal;

endmodule

// File: tb/tb_mux_rezultati_alu.sv
// Testbench for mux_rezultati_alu: scoreboard-checked random traffic plus
// directed reset, latency, stall, illegal-select and reset-while-full cases.
module tb_mux_rezultati_alu;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int SW = 3;
  localparam int NB = 6;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  mux_rezultati_alu_if #(.WIDTH(W), .NUM_IN(N),  .SEL_W(SW)) bus ();
  mux_rezultati_alu_if #(.WIDTH(W), .NUM_IN(NB), .SEL_W(SW)) busb ();

  mux_rezultati_alu #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus)
  );
  mux_rezultati_alu #(.WIDTH(W), .NUM_IN(NB), .SEL_W(SW)) dutb (
    .Clock(Clock), .Reset(Reset), .bus(busb)
  );

  int errors = 0;
  int checks = 0;
  logic [W+3:0] sbq[$];

  // Reference: plain shift-and-mask channel pick, flags derived from the word
  function automatic logic [W+3:0] model(input logic [N*W-1:0] h,
                                         input logic [N-1:0] cy,
                                         input int s, input int nin);
    logic [W-1:0] d;
    logic c, il;
    if (s < nin) begin
      d  = W'(h >> (s * W));
      c  = cy[s];
      il = 1'b0;
    end else begin
      d  = '0;
      c  = 1'b0;
      il = 1'b1;
    end
    return {d, (d == 0), d[W-1], c, il};
  endfunction

  function automatic logic [W+3:0] cur();
    return {bus.Dalja, bus.Zero, bus.Negative, bus.Carry, bus.Illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic rand_in();
    bus.Hyrjet      = {$urandom, $urandom, $urandom, $urandom};
    bus.CarryHyrjet = N'($urandom);
    bus.S           = SW'($urandom_range(0, N - 1));
  endtask

  // Scoreboard monitor: pop on every output transfer, push on every input transfer
  always @(negedge Clock) begin
    logic [W+3:0] exp;
    if (Reset) begin
      sbq.delete();
    end else begin
      if (bus.Valid_out && bus.Ready_out) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h expected none", cur());
        end else begin
          exp = sbq.pop_front();
          if (cur() !== exp) begin
            errors++;
            $display("FAIL sb_out: got %h expected %h", cur(), exp);
          end
        end
      end
      if (bus.Valid_in && bus.Ready_in)
        sbq.push_back(model(bus.Hyrjet, bus.CarryHyrjet, int'(bus.S), N));
    end
  end

  initial begin
    logic [W+3:0] ea, eb, ed;
    Reset = 1'b1;
    bus.Hyrjet = '0; bus.CarryHyrjet = '0; bus.S = '0;
    bus.Valid_in = 1'b0; bus.Ready_out = 1'b0;
    busb.Hyrjet = '0; busb.CarryHyrjet = '0; busb.S = '0;
    busb.Valid_in = 1'b0; busb.Ready_out = 1'b0;

    // reset held for two cycles
    step(); step();
    chk("rst_valid_out", bus.Valid_out, 0);
    chk("rst_ready_in",  bus.Ready_in, 1);
    chk("rst_dalja",     bus.Dalja, 0);
    chk("rst_flags",     {bus.Zero, bus.Negative, bus.Carry, bus.Illegal}, 0);

    // single beat on channel 5, and illegal selects on the 6-channel instance
    Reset = 1'b0;
    bus.Hyrjet = '0;
    bus.Hyrjet[5*W +: W] = 16'h8001;
    bus.CarryHyrjet = 8'b0010_0000;
    bus.S = 3'd5;
    bus.Valid_in = 1'b1;
    bus.Ready_out = 1'b1;
    busb.Hyrjet = {$urandom, $urandom, $urandom};
    busb.CarryHyrjet = '1;
    busb.S = 3'd7;
    busb.Valid_in = 1'b1;
    busb.Ready_out = 1'b1;
    step();
    bus.Valid_in = 1'b0;
    busb.S = 3'd6;
    chk("beat_valid",   bus.Valid_out, 1);
    chk("beat_dalja",   bus.Dalja, 16'h8001);
    chk("beat_flags",   {bus.Zero, bus.Negative, bus.Carry, bus.Illegal}, 4'b0110);
    chk("ill7_valid",   busb.Valid_out, 1);
    chk("ill7_dalja",   busb.Dalja, 0);
    chk("ill7_flags",   {busb.Zero, busb.Negative, busb.Carry, busb.Illegal}, 4'b1001);
    step();
    busb.Valid_in = 1'b0;
    chk("beat_one_cycle", bus.Valid_out, 0);
    chk("ill6_dalja",   busb.Dalja, 0);
    chk("ill6_flags",   {busb.Zero, busb.Negative, busb.Carry, busb.Illegal}, 4'b1001);

    // A, B, C back to back into a stalled output
    bus.Ready_out = 1'b0;
    rand_in(); bus.Valid_in = 1'b1;
    ea = model(bus.Hyrjet, bus.CarryHyrjet, int'(bus.S), N);
    step();
    rand_in();
    eb = model(bus.Hyrjet, bus.CarryHyrjet, int'(bus.S), N);
    step();
    chk("full_ready_in", bus.Ready_in, 0);
    rand_in();
    step();
    chk("full_hold_a",  cur(), ea);
    chk("full_valid",   bus.Valid_out, 1);
    chk("full_ready2",  bus.Ready_in, 0);
    rand_in();
    step();
    chk("full_stable_a", cur(), ea);
    bus.Valid_in = 1'b0;
    bus.Ready_out = 1'b1;
    step();
    chk("drain_b",      cur(), eb);
    chk("drain_ready",  bus.Ready_in, 1);
    step();
    chk("drain_no_c",   bus.Valid_out, 0);

    // reset while full and stalled
    bus.Ready_out = 1'b0;
    rand_in(); bus.Valid_in = 1'b1;
    step();
    rand_in();
    step();
    rand_in();
    Reset = 1'b1;
    step();
    chk("rfull_valid",  bus.Valid_out, 0);
    chk("rfull_ready",  bus.Ready_in, 1);
    chk("rfull_entry",  cur(), 0);
    Reset = 1'b0;
    rand_in();
    bus.Ready_out = 1'b1;
    ed = model(bus.Hyrjet, bus.CarryHyrjet, int'(bus.S), N);
    step();
    bus.Valid_in = 1'b0;
    chk("rfull_first",  cur(), ed);
    chk("rfull_fvalid", bus.Valid_out, 1);
    step();
    chk("rfull_only",   bus.Valid_out, 0);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      rand_in();
      bus.Valid_in  = ($urandom_range(0, 3) != 0);
      bus.Ready_out = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.Valid_in = 1'b0;
    bus.Ready_out = 1'b1;
    repeat (4) step();
    chk("sb_drained", sbq.size(), 0);
    chk("end_valid",  bus.Valid_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
